// File: rtl/hex_disp_pkg.sv
// Shared constants and width helper for the hex display driver.
// Segment codes are {g,f,e,d,c,b,a}, active low.
package hex_disp_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hex_disp.sv
// Combinational hex nibble to active-low 7-segment decoder; unknown nibbles show a dash.
// Zero latency, no flow control.
module hex_disp
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/hex_disp_mux.sv
// Scans a latched hex word across a multiplexed 7-segment display, one digit per slot.
// Outputs registered (1 cycle from counter state); no backpressure, load accepted every cycle.
module hex_disp_mux
  import hex_disp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 1000,
  parameter int AN_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int IDX_W = clog2_min1(DIGITS);
  localparam int CNT_W = clog2_min1(CLK_DIV);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh, blank_sh;
  logic                lz_sh;

  logic [DIGITS-1:0]   lz_sup, an_act, an_nxt;
  logic [3:0]          nib;
  logic [6:0]          seg_dec, seg_nxt;
  logic                dp_nxt, tick_nxt, dark, allz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh  <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      lz_sh    <= 1'b0;
    end else if (load) begin
      data_sh  <= data;
      dp_sh    <= dp_in;
      blank_sh <= blank_mask;
      lz_sh    <= lz_en;
    end
  end

  always_comb begin
    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nxt = idx;
    if (cnt == CNT_LAST) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    tick_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_sup = '0;
    allz   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      allz      = allz & (data_sh[4*i +: 4] == 4'h0);
      lz_sup[i] = allz;
    end
  end

  always_comb begin
    nib = data_sh[4*idx_nxt +: 4];
  end

  hex_disp u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  // Slot cycle 0 keeps every anode off so the previous digit cannot ghost into the next.
  always_comb begin
    an_act  = '0;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    dark    = blank_sh[idx_nxt] | (lz_sh & lz_sup[idx_nxt]);
    if (cnt_nxt != '0) begin
      an_act[idx_nxt] = 1'b1;
      seg_nxt         = dark ? SEG_OFF : seg_dec;
      dp_nxt          = blank_sh[idx_nxt] | ~dp_sh[idx_nxt];
    end
    an_nxt = (AN_ACT_LOW != 0) ? ~an_act : an_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_hex_disp_mux.sv
// Directed bench for hex_disp_mux with DIGITS=4, CLK_DIV=4, active-low anodes.
// Outputs sampled on the falling edge; expected values are hand-computed constants.
module tb_hex_disp_mux;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_cmp;
  int n_err;

  hex_disp_mux #(
    .DIGITS     (4),
    .CLK_DIV    (4),
    .AN_ACT_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpi,
                         input logic [3:0] blk, input logic lz);
    @(negedge clk);
    data       = d;
    dp_in      = dpi;
    blank_mask = blk;
    lz_en      = lz;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  // Returns at the falling edge of the last cycle of a frame (idx 3, cnt 3).
  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s tick_timeout: frame_tick=0 after 40 cycles, required a pulse", name);
    end
  endtask

  // segs = {d3,d2,d1,d0} segment codes, dps = per-digit dp output level.
  task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ft;
    one = 4'b0001;
    wait_tick(name);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        exp_an  = (c == 0) ? 4'hF : ~(one << d);
        exp_seg = (c == 0) ? 7'h7F : segs[7*d +: 7];
        exp_dp  = (c == 0) ? 1'b1 : dps[d];
        exp_ft  = (d == 3) && (c == 3);
        n_cmp++;
        if (an !== exp_an) begin
          n_err++;
          $display("FAIL %s an d%0d c%0d: got %h required %h", name, d, c, an, exp_an);
        end
        n_cmp++;
        if (seg !== exp_seg) begin
          n_err++;
          $display("FAIL %s seg d%0d c%0d: got %h required %h", name, d, c, seg, exp_seg);
        end
        n_cmp++;
        if (dp !== exp_dp) begin
          n_err++;
          $display("FAIL %s dp d%0d c%0d: got %b required %b", name, d, c, dp, exp_dp);
        end
        n_cmp++;
        if (frame_tick !== exp_ft) begin
          n_err++;
          $display("FAIL %s frame_tick d%0d c%0d: got %b required %b", name, d, c, frame_tick, exp_ft);
        end
      end
    end
  endtask

  task automatic test_reset();
    int first;
    int second;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: an=%h seg=%h dp=%b ft=%b required F 7f 1 0",
                 an, seg, dp, frame_tick);
      end
    end
    rst_n = 1'b1;
    first  = -1;
    second = -1;
    for (int k = 1; k <= 40 && second < 0; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        if (first < 0) first = k;
        else second = k;
      end
    end
    n_cmp++;
    if (first != 15) begin
      n_err++;
      $display("FAIL first_tick: cycle %0d required 15", first);
    end
    n_cmp++;
    if (second - first != 16) begin
      n_err++;
      $display("FAIL tick_period: %0d cycles required 16", second - first);
    end
    check_frame("reset_zero", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
  endtask

  task automatic test_decode();
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    check_frame("scan_12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);
    do_load(16'h3210, 4'h0, 4'h0, 1'b0);
    check_frame("dec_3210", {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF);
    do_load(16'h7654, 4'h0, 4'h0, 1'b0);
    check_frame("dec_7654", {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF);
    do_load(16'hBA98, 4'h0, 4'h0, 1'b0);
    check_frame("dec_BA98", {7'h03, 7'h08, 7'h10, 7'h00}, 4'hF);
    do_load(16'hFEDC, 4'h0, 4'h0, 1'b0);
    check_frame("dec_FEDC", {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF);
  endtask

  task automatic test_lz();
    do_load(16'h0070, 4'h0, 4'h0, 1'b1);
    check_frame("lz_0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);
    do_load(16'h0105, 4'h0, 4'h0, 1'b1);
    check_frame("lz_0105", {7'h7F, 7'h79, 7'h40, 7'h12}, 4'hF);
    do_load(16'h0000, 4'b0100, 4'h0, 1'b1);
    check_frame("lz_zero_dp", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011);
    do_load(16'h0070, 4'h0, 4'h0, 1'b0);
    check_frame("lz_off", {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF);
  endtask

  task automatic test_blank();
    do_load(16'h8888, 4'b0011, 4'b0010, 1'b0);
    check_frame("blank_d1", {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b1110);
  endtask

  task automatic test_back_to_back();
    wait_tick("b2b");
    data       = 16'h0009;
    dp_in      = 4'h0;
    blank_mask = 4'h0;
    lz_en      = 1'b0;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    data = 16'hFFFF;
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      n_err++;
      $display("FAIL b2b_guard: an=%h seg=%h required F 7f", an, seg);
    end
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hE || seg !== 7'h10) begin
      n_err++;
      $display("FAIL b2b_first: an=%h seg=%h required e 10", an, seg);
    end
    check_frame("b2b_hold", {7'h40, 7'h40, 7'h40, 7'h10}, 4'hF);
  endtask

  task automatic test_mid_reset();
    do_load(16'h4321, 4'h0, 4'h0, 1'b0);
    wait_tick("mid_reset");
    for (int i = 0; i < 7; i++) @(negedge clk);
    n_cmp++;
    if (an !== 4'hD || seg !== 7'h24) begin
      n_err++;
      $display("FAIL mid_pre: an=%h seg=%h required d 24", an, seg);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      n_err++;
      $display("FAIL mid_async: an=%h seg=%h dp=%b required F 7f 1", an, seg, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hE || seg !== 7'h40 || dp !== 1'b1) begin
      n_err++;
      $display("FAIL mid_restart: an=%h seg=%h dp=%b required e 40 1", an, seg, dp);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    load       = 1'b0;
    data       = '0;
    dp_in      = '0;
    blank_mask = '0;
    lz_en      = 1'b0;
    test_reset();
    test_decode();
    test_lz();
    test_blank();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
